// File: rtl/swt_seq_ctrl_if.sv
// Bus between the switch stimulus sequencer and whoever drives/observes it.
// The sequencer sits on the slave side; a board wrapper or testbench is the master.
// Control semantics: start and abort are single-cycle pulses sampled on the
// rising clock edge; pause is a level. There is no valid/ready pair: outputs are
// registered and always valid, and the master may change inputs on any cycle.
interface swt_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] swt_in;
    logic [WIDTH-1:0] swt_out;
    logic [WIDTH-1:0] step;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    modport master (
        output start, pause, abort, swt_in,
        input  swt_out, step, busy, done, state_dbg
    );

    modport slave (
        input  start, pause, abort, swt_in,
        output swt_out, step, busy, done, state_dbg
    );
endinterface

// File: rtl/swt_seq_ctrl.sv
// Stimulus sequencer for the switch-to-LED datapath.
// IDLE passes the board switches through (one register stage); RUN steps
// swt_out through 0..LAST, holding each value for DWELL cycles; HOLD freezes
// the sequence while pause is high; DONE parks on LAST.
// Optional feature macro: SEQ_WRAP_EN -- when defined, the sequence wraps from
// LAST back to 0 and loops until abort (DONE is never entered).
// state_dbg exposes the FSM encoding: 0=IDLE, 1=RUN, 2=HOLD, 3=DONE.
module swt_seq_ctrl #(
    parameter int          WIDTH = 8,
    parameter int          DWELL = 50,
    parameter int unsigned LAST  = 8'h17
) (
    input  logic          clk,
    input  logic          reset,
    swt_seq_ctrl_if.slave bus
);

    localparam int               CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(DWELL - 1);
    localparam logic [WIDTH-1:0] LAST_V  = WIDTH'(LAST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] swt_q, swt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             adv;

    // State and all registered outputs; reset returns everything to zero/IDLE at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            swt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            swt_q   <= swt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; abort is applied last so it overrides start and pause.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        swt_d   = swt_q;
        adv     = 1'b0;

        case (state_q)
            IDLE: begin
                swt_d  = bus.swt_in;
                step_d = '0;
                cnt_d  = '0;
                if (bus.start) begin
                    state_d = RUN;
                    swt_d   = '0;
                end
            end
            RUN: begin
                // The edge that samples pause does not count towards the dwell.
                if (bus.pause) begin
                    state_d = HOLD;
                end else begin
                    adv = 1'b1;
                end
            end
            HOLD: begin
                // Leaving HOLD counts as a normal RUN cycle, so the dwell of the
                // current value is extended by exactly the number of paused edges.
                if (!bus.pause) begin
                    state_d = RUN;
                    adv     = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    step_d  = '0;
                    swt_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (adv) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                if (step_q != LAST_V) begin
                    step_d = step_q + WIDTH'(1);
                    swt_d  = step_q + WIDTH'(1);
                end else begin
`ifdef SEQ_WRAP_EN
                    step_d  = '0;
                    swt_d   = '0;
                    state_d = RUN;
`else
                    state_d = DONE;
`endif
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // swt_out holds for the abort edge; pass-through restarts from IDLE on the next edge.
        if (bus.abort) begin
            state_d = IDLE;
            step_d  = '0;
            cnt_d   = '0;
            swt_d   = swt_q;
        end
    end

    // busy/done are registered copies of the next state so they align with swt_out.
    always_comb begin
        busy_d = (state_d == RUN) || (state_d == HOLD);
        done_d = (state_d == DONE);
    end

    assign bus.swt_out   = swt_q;
    assign bus.step      = step_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule
